// File: rtl/pwm_capture.sv
// PWM input capture: synchronizes an external PWM pin, measures high time and
// rising-to-rising period in clk cycles, and flags lines stuck high or low.
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_valid,
  output logic             stuck_high,
  output logic             stuck_low,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] per_inc;
  logic [CNT_W-1:0] high_d, period_d;
  logic             valid_d, sh_d, sl_d;

  assign s         = sync_q[SYNC_STAGES-1];
  assign rise      = s & ~prev_q;
  assign fall      = ~s & prev_q;
  assign fsm_state = state_q;

  // The synchronizer and edge detector ignore ena so edges stay coherent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      prev_q <= s;
    end
  end

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    high_d   = high_cnt;
    period_d = period_cnt;
    valid_d  = 1'b0;
    sh_d     = stuck_high;
    sl_d     = stuck_low;
    // Period counter saturates so it can never wrap past the timeout value.
    per_inc  = (per_q == TO) ? per_q : per_q + ONE;

    if (!ena) begin
      state_d = IDLE;
      hi_d    = '0;
      per_d   = '0;
    end else if ((per_q == TO) && !rise && !fall) begin
      sh_d    = s;
      sl_d    = ~s;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rise) begin
            hi_d    = ONE;
            per_d   = ONE;
            state_d = HIGH;
          end else begin
            per_d = per_inc;
          end
        end
        HIGH: begin
          per_d = per_inc;
          if (fall) state_d = LOW;
          else      hi_d    = hi_q + ONE;
        end
        LOW: begin
          if (rise) begin
            high_d   = hi_q;
            period_d = per_q;
            valid_d  = 1'b1;
            sh_d     = 1'b0;
            sl_d     = 1'b0;
            hi_d     = ONE;
            per_d    = ONE;
            state_d  = HIGH;
          end else begin
            per_d = per_inc;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      hi_q       <= '0;
      per_q      <= '0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_valid <= 1'b0;
      stuck_high <= 1'b0;
      stuck_low  <= 1'b0;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      per_q      <= per_d;
      high_cnt   <= high_d;
      period_cnt <= period_d;
      meas_valid <= valid_d;
      stuck_high <= sh_d;
      stuck_low  <= sl_d;
    end
  end

endmodule
